clk_tick_recv: RTL and testbench

//   Receiving end of the slow-clock divider chain: brings clk6hz and clk191hz back into
//   the clk50Mhz domain. Per channel: synchronise, edge-detect to 1-cycle ticks, measure

---
 rtl/clk_tick_pkg.sv | 33 +++
 rtl/clk_tick_recv_channel.sv | 118 +++++++++++
 rtl/clk_tick_recv.sv | 69 ++++++
 tb/tb_clk_tick_recv.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_tick_pkg.sv
// Shared types and constants for the slow-clock tick receiver.
// State encoding, nominal periods and default windows/timeouts.
package clk_tick_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam int unsigned NOM191 = 2**18;
  localparam int unsigned NOM6   = 2**23;

  localparam int unsigned DEF_SYNC       = 2;
  localparam int unsigned DEF_CW         = 24;
  localparam int unsigned DEF_P191_MIN   = 255000;
  localparam int unsigned DEF_P191_MAX   = 269000;
  localparam int unsigned DEF_P6_MIN     = 8150000;
  localparam int unsigned DEF_P6_MAX     = 8630000;
  localparam int unsigned DEF_TO191      = 2 * NOM191;
  localparam int unsigned DEF_TO6        = 16777215;
  localparam int unsigned DEF_LOCK_EDGES = 4;

  // Inclusive period window test.
  function automatic logic in_win(
    input int unsigned v,
    input int unsigned lo,
    input int unsigned hi
  );
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/clk_tick_recv_channel.sv
// One receive channel: synchroniser, edge tick, period counter
// and SEARCH/ACQUIRE/LOCKED lock tracker.
module tick_channel
  import clk_tick_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CW          = 24,
  parameter int unsigned PMIN        = 255000,
  parameter int unsigned PMAX        = 269000,
  parameter int unsigned TO          = 524288,
  parameter int unsigned LOCK_EDGES  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          din,
  output logic          tick,
  output logic          lock,
  output logic          leave,
  output logic [CW-1:0] period
);

  localparam logic [CW-1:0] TO_C = CW'(TO);
  localparam logic [2:0]    LE_C = 3'(LOCK_EDGES);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   edge_c;
  logic                   win;
  logic                   tmo;
  logic [CW-1:0]          cnt;
  logic [2:0]             good;
  state_t                 state;

  assign edge_c = sync[SYNC_STAGES-1] & ~prev;
  assign win    = in_win(32'(cnt), PMIN, PMAX);
  assign tmo    = (cnt == TO_C);

  // Synchronise the divided clock and emit a one-cycle rising tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      prev <= 1'b0;
      tick <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      prev <= sync[SYNC_STAGES-1];
      tick <= edge_c;
    end
  end

  // Tick-to-tick period counter, saturating at the timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      period <= '0;
    end else if (edge_c) begin
      period <= cnt;
      cnt    <= CW'(1);
    end else if (!tmo) begin
      cnt    <= cnt + CW'(1);
    end
  end

  // Lock tracker; a tick takes priority over a same-cycle timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEARCH;
      good  <= 3'd0;
      lock  <= 1'b0;
      leave <= 1'b0;
    end else begin
      leave <= 1'b0;
      unique case (state)
        SEARCH: begin
          if (edge_c) begin
            state <= ACQUIRE;
            good  <= 3'd0;
          end
        end
        ACQUIRE: begin
          if (edge_c) begin
            if (!win) begin
              good <= 3'd0;
            end else if (good + 3'd1 == LE_C) begin
              state <= LOCKED;
              lock  <= 1'b1;
              good  <= 3'd0;
            end else begin
              good <= good + 3'd1;
            end
          end else if (tmo) begin
            state <= SEARCH;
          end
        end
        LOCKED: begin
          if (edge_c) begin
            if (!win) begin
              state <= ACQUIRE;
              good  <= 3'd0;
              lock  <= 1'b0;
              leave <= 1'b1;
            end
          end else if (tmo) begin
            state <= SEARCH;
            lock  <= 1'b0;
            leave <= 1'b1;
          end
        end
        default: begin
          state <= SEARCH;
          good  <= 3'd0;
          lock  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/clk_tick_recv.sv
// Brings clk6hz/clk191hz into the clk50Mhz domain as ticks,
// with per-channel period measurement and lock/loss reporting.
module clk_tick_recv
  import clk_tick_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC,
  parameter int unsigned CW          = DEF_CW,
  parameter int unsigned P191_MIN    = DEF_P191_MIN,
  parameter int unsigned P191_MAX    = DEF_P191_MAX,
  parameter int unsigned P6_MIN      = DEF_P6_MIN,
  parameter int unsigned P6_MAX      = DEF_P6_MAX,
  parameter int unsigned TO191       = DEF_TO191,
  parameter int unsigned TO6         = DEF_TO6,
  parameter int unsigned LOCK_EDGES  = DEF_LOCK_EDGES
) (
  input  logic          clk50Mhz,
  input  logic          rst_n,
  input  logic          clk6hz,
  input  logic          clk191hz,
  output logic          tick6hz,
  output logic          tick191hz,
  output logic          lock6hz,
  output logic          lock191hz,
  output logic          lost,
  output logic [CW-1:0] period6,
  output logic [CW-1:0] period191
);

  logic leave6;
  logic leave191;

  tick_channel #(
    .SYNC_STAGES(SYNC_STAGES),
    .CW         (CW),
    .PMIN       (P6_MIN),
    .PMAX       (P6_MAX),
    .TO         (TO6),
    .LOCK_EDGES (LOCK_EDGES)
  ) u_ch6 (
    .clk   (clk50Mhz),
    .rst_n (rst_n),
    .din   (clk6hz),
    .tick  (tick6hz),
    .lock  (lock6hz),
    .leave (leave6),
    .period(period6)
  );

  tick_channel #(
    .SYNC_STAGES(SYNC_STAGES),
    .CW         (CW),
    .PMIN       (P191_MIN),
    .PMAX       (P191_MAX),
    .TO         (TO191),
    .LOCK_EDGES (LOCK_EDGES)
  ) u_ch191 (
    .clk   (clk50Mhz),
    .rst_n (rst_n),
    .din   (clk191hz),
    .tick  (tick191hz),
    .lock  (lock191hz),
    .leave (leave191),
    .period(period191)
  );

  // Simultaneous loss on both channels merges into one pulse.
  assign lost = leave6 | leave191;

endmodule

// File: tb/tb_clk_tick_recv.sv
// Bench for clk_tick_recv: run-length lock model, boundary
// table, hand-written corner sequences and random waveforms.
module tb_clk_tick_recv;

  localparam int CW   = 8;
  localparam int PMIN = 90;
  localparam int PMAX = 110;
  localparam int TO   = 200;
  localparam int LE   = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clk6hz = 1'b0;
  logic          clk191hz = 1'b0;
  logic          tick6hz, tick191hz;
  logic          lock6hz, lock191hz;
  logic          lost;
  logic [CW-1:0] period6, period191;

  clk_tick_recv #(
    .SYNC_STAGES(2),
    .CW         (CW),
    .P191_MIN   (PMIN),
    .P191_MAX   (PMAX),
    .P6_MIN     (PMIN),
    .P6_MAX     (PMAX),
    .TO191      (TO),
    .TO6        (TO),
    .LOCK_EDGES (LE)
  ) dut (
    .clk50Mhz (clk),
    .rst_n    (rst_n),
    .clk6hz   (clk6hz),
    .clk191hz (clk191hz),
    .tick6hz  (tick6hz),
    .tick191hz(tick191hz),
    .lock6hz  (lock6hz),
    .lock191hz(lock191hz),
    .lost     (lost),
    .period6  (period6),
    .period191(period191)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int lost_seen = 0;

  // Reference: sampled history, reference time of the last
  // tick/reset, a search flag and a run of good periods.
  bit h [2][3];
  int base [2];
  bit srch [2];
  int run [2];
  int e_per [2];
  bit e_tick [2];
  bit e_lock [2];
  bit e_leave [2];

  function automatic void chk(
    input string nm,
    input logic [31:0] a,
    input logic [31:0] e
  );
    n_chk++;
    if (a !== e) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                 nm, a, e, cyc);
    end
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 3; k++) h[c][k] = 1'b0;
      base[c]    = cyc;
      srch[c]    = 1'b1;
      run[c]     = 0;
      e_per[c]   = 0;
      e_tick[c]  = 1'b0;
      e_lock[c]  = 1'b0;
      e_leave[c] = 1'b0;
    end
  endfunction

  function automatic void model_edge(input int c, input bit x);
    bit ev;
    int cp;
    ev = h[c][1] & ~h[c][2];
    cp = cyc - 1 - base[c];
    if (cp > TO) cp = TO;
    e_leave[c] = 1'b0;
    if (ev) begin
      e_per[c] = cp;
      base[c]  = cyc - 1;
      if (srch[c]) begin
        srch[c] = 1'b0;
        run[c]  = 0;
      end else if (cp >= PMIN && cp <= PMAX) begin
        run[c]++;
      end else begin
        if (run[c] >= LE) e_leave[c] = 1'b1;
        run[c] = 0;
      end
    end else if (cp == TO && !srch[c]) begin
      if (run[c] >= LE) e_leave[c] = 1'b1;
      srch[c] = 1'b1;
      run[c]  = 0;
    end
    e_tick[c] = ev;
    e_lock[c] = !srch[c] && (run[c] >= LE);
    h[c][2] = h[c][1];
    h[c][1] = h[c][0];
    h[c][0] = x;
  endfunction

  task automatic step(input logic a6, input logic a191);
    clk6hz   = a6;
    clk191hz = a191;
    @(posedge clk);
    #1;
    cyc++;
    model_edge(0, a6);
    model_edge(1, a191);
    if (lost === 1'b1) lost_seen++;
    chk("tick6", tick6hz, e_tick[0]);
    chk("tick191", tick191hz, e_tick[1]);
    chk("lock6", lock6hz, e_lock[0]);
    chk("lock191", lock191hz, e_lock[1]);
    chk("lost", lost, e_leave[0] | e_leave[1]);
    chk("period6", period6, e_per[0]);
    chk("period191", period191, e_per[1]);
  endtask

  task automatic sq(input logic [1:0] m, input int per, input int np);
    for (int k = 0; k < np; k++)
      for (int j = 0; j < per; j++)
        step(m[0] && (j < per / 2), m[1] && (j < per / 2));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  // Asynchronous reset between clock edges; outputs clear at once.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_tick6", tick6hz, 0);
    chk("rst_tick191", tick191hz, 0);
    chk("rst_lock6", lock6hz, 0);
    chk("rst_lock191", lock191hz, 0);
    chk("rst_lost", lost, 0);
    chk("rst_per6", period6, 0);
    chk("rst_per191", period191, 0);
    clk6hz   = 1'b0;
    clk191hz = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [1:0] m;
    int         per;
    logic       lk;
  } vec_t;

  vec_t tbl [7];
  int   gcnt [2];
  int   gper [2];

  function automatic int new_per();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return 230;
    if (r == 1) return $urandom_range(40, 85);
    return $urandom_range(86, 114);
  endfunction

  initial begin
    int l0;
    logic [1:0] v;

    tbl[0] = '{2'b10, 89, 1'b0};
    tbl[1] = '{2'b10, 90, 1'b1};
    tbl[2] = '{2'b10, 100, 1'b1};
    tbl[3] = '{2'b10, 110, 1'b1};
    tbl[4] = '{2'b10, 111, 1'b0};
    tbl[5] = '{2'b01, 90, 1'b1};
    tbl[6] = '{2'b01, 111, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("init_lock", {lock6hz, lock191hz}, 0);
    chk("init_tick", {tick6hz, tick191hz}, 0);
    chk("init_lost", lost, 0);
    chk("init_per", {period6, period191}, 0);
    rst_n = 1'b1;
    model_reset();

    // Latency: high one cycle after release, tick on 3rd edge.
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    chk("lat_e1", tick191hz, 0);
    step(1'b1, 1'b1);
    chk("lat_e2", tick191hz, 0);
    step(1'b1, 1'b1);
    chk("lat_e3_191", tick191hz, 1);
    chk("lat_e3_6", tick6hz, 1);
    step(1'b1, 1'b1);
    chk("lat_width", {tick6hz, tick191hz}, 0);
    idle(20);

    // Lock at the 5th tick, drop on a long period, relock.
    do_reset();
    sq(2'b10, 100, 4);
    chk("lock_pre", lock191hz, 0);
    sq(2'b10, 100, 1);
    chk("lock_5th", lock191hz, 1);
    chk("per100", period191, 100);
    l0 = lost_seen;
    sq(2'b10, 120, 1);
    sq(2'b10, 100, 1);
    chk("drop_lock", lock191hz, 0);
    chk("drop_lost", lost_seen - l0, 1);
    chk("drop_per", period191, 120);
    sq(2'b10, 100, 3);
    chk("relock_pre", lock191hz, 0);
    sq(2'b10, 100, 1);
    chk("relock", lock191hz, 1);

    // Input held low: timeout, single loss, counter saturates.
    l0 = lost_seen;
    idle(250);
    chk("to_lock", lock191hz, 0);
    chk("to_lost", lost_seen - l0, 1);
    sq(2'b10, 100, 1);
    chk("sat_per", period191, TO);
    chk("sat_lock", lock191hz, 0);

    // Inclusive window boundaries on both channels.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      sq(tbl[i].m, tbl[i].per, 5);
      chk("tbl_lock6", lock6hz, tbl[i].m[0] & tbl[i].lk);
      chk("tbl_lock191", lock191hz, tbl[i].m[1] & tbl[i].lk);
      chk("tbl_per",
          tbl[i].m[1] ? period191 : period6, tbl[i].per);
    end

    // Both channels lose lock together: one merged pulse.
    do_reset();
    sq(2'b11, 100, 5);
    chk("both_lock", {lock6hz, lock191hz}, 2'b11);
    l0 = lost_seen;
    idle(250);
    chk("both_lost", lost_seen - l0, 1);
    chk("both_drop", {lock6hz, lock191hz}, 0);

    // Reset asserted while locked.
    sq(2'b11, 100, 5);
    chk("pre_rst_lock", {lock6hz, lock191hz}, 2'b11);
    do_reset();

    // Random independent waveforms against the model.
    for (int c = 0; c < 2; c++) begin
      gper[c] = new_per();
      gcnt[c] = $urandom_range(0, gper[c] - 1);
    end
    for (int i = 0; i < 8000; i++) begin
      for (int c = 0; c < 2; c++) begin
        v[c] = (gcnt[c] < gper[c] / 2);
        gcnt[c]++;
        if (gcnt[c] >= gper[c]) begin
          gcnt[c] = 0;
          gper[c] = new_per();
        end
      end
      step(v[0], v[1]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
